speed_balancer: RTL and testbench
=================================

SPEED_BALANCER -- requirements
Module: speed_balancer

Interface
REQ-001 SHALL have parameter WINDOW, default 100000, meaning RUN-state clock cycles per sample window (>=2).
REQ-002 SHALL have parameter DUTY_NOM, default 128, meaning the duty value loaded into both motors on start.
REQ-003 SHALL have parameter STEP, default 1, meaning the duty increment/decrement per adjustment.
REQ-004 SHALL have parameter DEADBAND, default 2, meaning the largest |pos_diff| that causes no adjustment.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable  input  1  level; high = balancing active.
REQ-008 SHALL have port pos12  input  16  motor-1 edge count from position manager.
REQ-009 SHALL have port pos22  input  16  motor-2 edge count from position manager.
REQ-010 SHALL have port pos_diff  input  16  pos12-pos22, two's-complement signed.
REQ-011 SHALL have port clear  output  2  clear request to position manager (bit0 clock counter, bit1 position counters).
REQ-012 SHALL have port duty1  output  8  motor-1 PWM duty command.
REQ-013 SHALL have port duty2  output  8  motor-2 PWM duty command.
REQ-014 SHALL have port speed1  output  16  pos12 latched at end of last window.
REQ-015 SHALL have port speed2  output  16  pos22 latched at end of last window.
REQ-016 SHALL have port sample_valid  output  1  one-cycle pulse when speed1/speed2 update.

Function
REQ-017 SHALL implement FSM states IDLE, START, RUN, LATCH, ADJUST, CLR; all outputs registered.
REQ-018 IDLE: clear=00, duty1=duty2=0; enable high -> START.
REQ-019 START (1 cycle): clear=11, duty1=duty2=DUTY_NOM, window counter=0 -> RUN.
REQ-020 RUN: clear=00, counter increments each cycle; at counter==WINDOW-1 -> LATCH.
REQ-021 LATCH (1 cycle): speed1<=pos12, speed2<=pos22, diff register<=pos_diff, sample_valid=1 in the cycle after the capture edge -> ADJUST.
REQ-022 ADJUST (1 cycle): signed diff > DEADBAND -> duty1-=STEP, duty2+=STEP; diff < -DEADBAND -> duty1+=STEP, duty2-=STEP; otherwise no change -> CLR.
REQ-023 Duty arithmetic SHALL saturate independently at 0 and 255; no wrap-around; saturation of one duty does not block the other's update.
REQ-024 diff == +DEADBAND or -DEADBAND exactly SHALL cause no adjustment.
REQ-025 CLR (1 cycle): clear=11, counter=0 -> RUN; sample period = WINDOW+3 cycles.
REQ-026 enable low in any state SHALL force IDLE on next edge; pending adjustment discarded; duties 0, clear=00; speed1/speed2 hold.
REQ-027 enable re-asserted SHALL restart via START (duties reset to DUTY_NOM).
REQ-028 sample_valid SHALL be high only for exactly one cycle per window, never in IDLE/START.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force state IDLE, counter 0, clear=00, duty1=duty2=0, speed1=speed2=0, sample_valid=0.
REQ-030 After rst_n release with enable high, first START SHALL occur on the first clk edge after release.

Verification (bench uses WINDOW=8, defaults otherwise)
REQ-031 rst_n pulsed low mid-RUN with duty1=130 -> all outputs 0 within the reset assertion, no clock needed; IDLE after release with enable low.
REQ-032 enable 0->1 -> clear=11 for one cycle, duty1=duty2=128, sample_valid after 8 RUN + LATCH, clear=11 again 11 cycles after START.
REQ-033 pos12=20, pos22=15, pos_diff=5 at LATCH -> speed1=20, speed2=15, duty1=127, duty2=129.
REQ-034 pos_diff=0xFFFB (-5) -> duty1=129, duty2=127; pos_diff=2 or 0xFFFE -> duties unchanged.
REQ-035 duty2=255, duty1=1, pos_diff=+10 for two windows -> duty2 stays 255, duty1 goes 0 then stays 0.
REQ-036 enable dropped during ADJUST with pos_diff=+5 -> no duty change applied, next cycle IDLE, duties 0, clear=00, speed1/speed2 retained.

Source files
------------

// File: rtl/speed_balancer.sv
// speed_balancer: windowed speed sampler and differential duty trimmer for a
// two-motor drive. Each window it latches both edge counts, then nudges the
// duties in opposite directions to pull the position difference back inside
// the deadband.
module speed_balancer #(
  parameter int unsigned WINDOW   = 100000,
  parameter int unsigned DUTY_NOM = 128,
  parameter int unsigned STEP     = 1,
  parameter int unsigned DEADBAND = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pos12,
  input  logic [15:0] pos22,
  input  logic [15:0] pos_diff,
  output logic [1:0]  clear,
  output logic [7:0]  duty1,
  output logic [7:0]  duty2,
  output logic [15:0] speed1,
  output logic [15:0] speed2,
  output logic        sample_valid
);

  localparam int unsigned CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(WINDOW - 1);
  localparam logic [7:0]           NOM8     = 8'(DUTY_NOM);
  localparam logic [7:0]           STEP8    = 8'(STEP);
  localparam logic signed [15:0]   DB_POS   = 16'(DEADBAND);
  localparam logic signed [15:0]   DB_NEG   = -DB_POS;

  typedef enum logic [2:0] {IDLE, START, RUN, LATCH, ADJUST, CLR} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     clear_q, clear_d;
  logic [7:0]     duty1_q, duty1_d;
  logic [7:0]     duty2_q, duty2_d;
  logic [15:0]    speed1_q, speed1_d;
  logic [15:0]    speed2_q, speed2_d;
  logic [15:0]    diff_q, diff_d;
  logic           sv_q, sv_d;

  function automatic logic [7:0] sat_dec(input logic [7:0] d);
    if (d < STEP8) return '0;
    return d - STEP8;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] d);
    if (d > (8'hFF - STEP8)) return '1;
    return d + STEP8;
  endfunction

  // Registered outputs are computed from the state being entered, so each
  // output value is visible for exactly the cycle its state is occupied.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear_d  = 2'b00;
    duty1_d  = duty1_q;
    duty2_d  = duty2_q;
    speed1_d = speed1_q;
    speed2_d = speed2_q;
    diff_d   = diff_q;
    sv_d     = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      duty1_d = '0;
      duty2_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = START;
          clear_d = 2'b11;
          duty1_d = NOM8;
          duty2_d = NOM8;
          cnt_d   = '0;
        end
        START: begin
          state_d = RUN;
          cnt_d   = '0;
        end
        RUN: begin
          if (cnt_q == CNT_LAST) state_d = LATCH;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        LATCH: begin
          state_d  = ADJUST;
          speed1_d = pos12;
          speed2_d = pos22;
          diff_d   = pos_diff;
          sv_d     = 1'b1;
        end
        ADJUST: begin
          state_d = CLR;
          clear_d = 2'b11;
          cnt_d   = '0;
          if ($signed(diff_q) > DB_POS) begin
            duty1_d = sat_dec(duty1_q);
            duty2_d = sat_inc(duty2_q);
          end else if ($signed(diff_q) < DB_NEG) begin
            duty1_d = sat_inc(duty1_q);
            duty2_d = sat_dec(duty2_q);
          end
        end
        CLR: begin
          state_d = RUN;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      clear_q  <= '0;
      duty1_q  <= '0;
      duty2_q  <= '0;
      speed1_q <= '0;
      speed2_q <= '0;
      diff_q   <= '0;
      sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clear_q  <= clear_d;
      duty1_q  <= duty1_d;
      duty2_q  <= duty2_d;
      speed1_q <= speed1_d;
      speed2_q <= speed2_d;
      diff_q   <= diff_d;
      sv_q     <= sv_d;
    end
  end

  assign clear        = clear_q;
  assign duty1        = duty1_q;
  assign duty2        = duty2_q;
  assign speed1       = speed1_q;
  assign speed2       = speed2_q;
  assign sample_valid = sv_q;

endmodule

// File: tb/tb_speed_balancer.sv
// Directed bench for speed_balancer with an 8-cycle sample window.
module tb_speed_balancer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] pos12, pos22, pos_diff;
  logic [1:0]  clear;
  logic [7:0]  duty1, duty2;
  logic [15:0] speed1, speed2;
  logic        sample_valid;

  int checks = 0;
  int errors = 0;

  speed_balancer #(.WINDOW(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pos12(pos12), .pos22(pos22), .pos_diff(pos_diff),
    .clear(clear), .duty1(duty1), .duty2(duty2),
    .speed1(speed1), .speed2(speed2), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_duty(input string tag, input logic [7:0] e1, input logic [7:0] e2);
    chk({tag, "_duty1"}, {8'h00, duty1}, {8'h00, e1});
    chk({tag, "_duty2"}, {8'h00, duty2}, {8'h00, e2});
  endtask

  // Starts right after the CLR/START cycle; ends in the following CLR cycle.
  task automatic run_window(input logic [15:0] p1, input logic [15:0] p2, input logic [15:0] pd,
                            input bit verbose);
    pos12 = p1; pos22 = p2; pos_diff = pd;
    repeat (9) tick();
    if (verbose) chk("latch_sv_low", {15'd0, sample_valid}, 16'd0);
    tick();
    if (verbose) begin
      chk("adjust_sv", {15'd0, sample_valid}, 16'd1);
      chk("speed1", speed1, p1);
      chk("speed2", speed2, p2);
    end
    tick();
    if (verbose) begin
      chk("clr_clear", {14'd0, clear}, 16'd3);
      chk("clr_sv_low", {15'd0, sample_valid}, 16'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; pos12 = '0; pos22 = '0; pos_diff = '0;
    tick(); tick();
    chk("rst_clear", {14'd0, clear}, 16'd0);
    chk_duty("rst", 8'd0, 8'd0);
    chk("rst_speed1", speed1, 16'd0);
    chk("rst_sv", {15'd0, sample_valid}, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_clear", {14'd0, clear}, 16'd0);

    // Start: one-cycle clear pulse and nominal duty.
    enable = 1'b1; pos12 = 16'd20; pos22 = 16'd15; pos_diff = 16'd5;
    tick();
    chk("start_clear", {14'd0, clear}, 16'd3);
    chk_duty("start", 8'd128, 8'd128);
    chk("start_sv", {15'd0, sample_valid}, 16'd0);
    tick();
    chk("run_clear", {14'd0, clear}, 16'd0);
    repeat (7) tick();
    chk("run_end_sv", {15'd0, sample_valid}, 16'd0);
    tick();
    chk("latch_sv", {15'd0, sample_valid}, 16'd0);
    tick();
    chk("first_sv", {15'd1 - 15'd1, sample_valid}, 16'd1);
    chk("first_speed1", speed1, 16'd20);
    chk("first_speed2", speed2, 16'd15);
    chk_duty("adjust_hold", 8'd128, 8'd128);
    tick();
    chk("clr11_clear", {14'd0, clear}, 16'd3);
    chk_duty("pos5", 8'd127, 8'd129);

    // Negative difference beyond deadband, then both deadband edges.
    run_window(16'd30, 16'd40, 16'hFFFB, 1'b1);
    chk_duty("neg5_a", 8'd128, 8'd128);
    run_window(16'd31, 16'd41, 16'hFFFB, 1'b1);
    chk_duty("neg5_b", 8'd129, 8'd127);
    run_window(16'd10, 16'd8, 16'd2, 1'b0);
    chk_duty("db_pos", 8'd129, 8'd127);
    run_window(16'd8, 16'd10, 16'hFFFE, 1'b0);
    chk_duty("db_neg", 8'd129, 8'd127);
    run_window(16'd9, 16'd9, 16'd3, 1'b0);
    chk_duty("pos3", 8'd128, 8'd128);

    // Enable dropped during ADJUST: adjustment discarded, speeds held.
    pos12 = 16'd50; pos22 = 16'd45; pos_diff = 16'd5;
    repeat (10) tick();
    chk("pre_drop_sv", {15'd0, sample_valid}, 16'd1);
    enable = 1'b0;
    tick();
    chk_duty("drop", 8'd0, 8'd0);
    chk("drop_clear", {14'd0, clear}, 16'd0);
    chk("drop_sv", {15'd0, sample_valid}, 16'd0);
    chk("drop_speed1", speed1, 16'd50);
    chk("drop_speed2", speed2, 16'd45);
    tick();
    chk_duty("drop_idle", 8'd0, 8'd0);

    // Restart goes through START with nominal duty; reach duty1=130 then reset mid-RUN.
    enable = 1'b1;
    tick();
    chk("restart_clear", {14'd0, clear}, 16'd3);
    chk_duty("restart", 8'd128, 8'd128);
    run_window(16'd1, 16'd2, 16'hFFF0, 1'b0);
    run_window(16'd3, 16'd4, 16'hFFF0, 1'b0);
    chk_duty("pre_rst", 8'd130, 8'd126);
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    chk_duty("async_rst", 8'd0, 8'd0);
    chk("async_rst_clear", {14'd0, clear}, 16'd0);
    chk("async_rst_speed1", speed1, 16'd0);
    chk("async_rst_speed2", speed2, 16'd0);
    chk("async_rst_sv", {15'd0, sample_valid}, 16'd0);
    enable = 1'b0;
    #1 rst_n = 1'b1;
    tick(); tick();
    chk_duty("post_rst_idle", 8'd0, 8'd0);
    chk("post_rst_clear", {14'd0, clear}, 16'd0);

    // Release reset with enable high: START on the first edge.
    rst_n = 1'b0; enable = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    chk("rel_start_clear", {14'd0, clear}, 16'd3);
    chk_duty("rel_start", 8'd128, 8'd128);

    // Saturation: 127 windows of +10 bring duty1 to 1 and duty2 to 255.
    for (int i = 0; i < 127; i++) run_window(16'd100, 16'd90, 16'd10, 1'b0);
    chk_duty("sat_pre", 8'd1, 8'd255);
    run_window(16'd100, 16'd90, 16'd10, 1'b0);
    chk_duty("sat_a", 8'd0, 8'd255);
    run_window(16'd100, 16'd90, 16'd10, 1'b0);
    chk_duty("sat_b", 8'd0, 8'd255);
    // Recovery from the floor/ceiling in the opposite direction.
    run_window(16'd90, 16'd100, 16'hFFF6, 1'b0);
    chk_duty("sat_back", 8'd1, 8'd254);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
